// File: rtl/alt_vipitc140_is2vid_pkg.sv
// Shared types for the IS2VID mode calculator: derived timing record,
// bank field map, control bit positions and controller states.
package alt_vipitc140_is2vid_pkg;

    localparam int TIMING_W   = 16;
    localparam int NUM_FIELDS = 20;

    localparam logic [4:0] FLD_SAMPLE_COUNT_F0  = 5'd0;
    localparam logic [4:0] FLD_LINE_COUNT_F0    = 5'd1;
    localparam logic [4:0] FLD_LINE_COUNT_F1    = 5'd2;
    localparam logic [4:0] FLD_H_BLANK          = 5'd3;
    localparam logic [4:0] FLD_H_FRONT_PORCH    = 5'd4;
    localparam logic [4:0] FLD_H_SYNC_LENGTH    = 5'd5;
    localparam logic [4:0] FLD_V_BLANK          = 5'd6;
    localparam logic [4:0] FLD_V1_BLANK         = 5'd7;
    localparam logic [4:0] FLD_V_FRONT_PORCH    = 5'd8;
    localparam logic [4:0] FLD_V_SYNC_LENGTH    = 5'd9;
    localparam logic [4:0] FLD_V1_FRONT_PORCH   = 5'd10;
    localparam logic [4:0] FLD_V1_SYNC_LENGTH   = 5'd11;
    localparam logic [4:0] FLD_V1_RISING_EDGE   = 5'd12;
    localparam logic [4:0] FLD_AP_LINE          = 5'd13;
    localparam logic [4:0] FLD_F_RISING_EDGE    = 5'd14;
    localparam logic [4:0] FLD_F_FALLING_EDGE   = 5'd15;
    localparam logic [4:0] FLD_ANC_LINE         = 5'd16;
    localparam logic [4:0] FLD_V1_ANC_LINE      = 5'd17;
    localparam logic [4:0] FLD_RESERVED         = 5'd18;
    localparam logic [4:0] FLD_CONTROL          = 5'd19;

    localparam int CTRL_INTERLACED = 0;
    localparam int CTRL_SERIAL     = 1;
    localparam int CTRL_BANK_VALID = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CALC1,
        ST_CALC2,
        ST_CALC3,
        ST_WAIT_EOF,
        ST_COMMIT
    } mode_state_e;

    typedef struct packed {
        logic [TIMING_W-1:0] h_total_m1;
        logic [TIMING_W-1:0] v_active;
        logic [TIMING_W-1:0] v_total;
        logic [TIMING_W-1:0] v_total_m1;
        logic [TIMING_W-1:0] ap_line_end;
        logic [TIMING_W-1:0] sav;
        logic [TIMING_W-1:0] h_sync_end;
        logic [TIMING_W-1:0] v1_rise;
        logic [TIMING_W-1:0] v2_rise;
        logic [TIMING_W-1:0] f1_v_end;
        logic [TIMING_W-1:0] f1_v_start;
        logic [TIMING_W-1:0] f1_v_sync_end;
        logic [TIMING_W-1:0] f2_v_start;
        logic [TIMING_W-1:0] f2_v_sync_end;
        logic [TIMING_W-1:0] f_rising;
        logic [TIMING_W-1:0] f_falling;
        logic [TIMING_W-1:0] f2_anc;
        logic [TIMING_W-1:0] f1_anc;
        logic [12:0]         total_line_count_f0;
        logic [12:0]         total_line_count_f1;
        logic                interlaced;
        logic                serial;
    } mode_timing_t;

endpackage

// File: rtl/alt_vipitc140_is2vid_mode_bank.sv
// Mode bank storage: NUM_MODES banks of NUM_FIELDS timing fields, one
// synchronous write port and one combinational whole-bank read port.
module alt_vipitc140_is2vid_mode_bank
    import alt_vipitc140_is2vid_pkg::*;
#(
    parameter int CNT_W     = TIMING_W,
    parameter int NUM_MODES = 4,
    parameter int MODE_W    = 2
) (
    input  logic                                clk_i,
    input  logic                                rst_n_i,
    input  logic                                wr_en_i,
    input  logic [MODE_W-1:0]                   wr_mode_i,
    input  logic [4:0]                          wr_addr_i,
    input  logic [CNT_W-1:0]                    wr_data_i,
    input  logic [MODE_W-1:0]                   rd_mode_i,
    output logic [NUM_FIELDS-1:0][CNT_W-1:0]    rd_bank_o
);

    logic [NUM_FIELDS-1:0][CNT_W-1:0] mem_q [NUM_MODES];

    // Field writes; addresses beyond the field map are silently dropped
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int m = 0; m < NUM_MODES; m++) begin
                mem_q[m] <= '0;
            end
        end else if (wr_en_i && (wr_addr_i < 5'(NUM_FIELDS)) && (int'(wr_mode_i) < NUM_MODES)) begin
            mem_q[wr_mode_i][wr_addr_i] <= wr_data_i;
        end
    end

    // Whole-bank read of the selected mode, zero for unpopulated indices
    always_comb begin
        rd_bank_o = '0;
        if (int'(rd_mode_i) < NUM_MODES) begin
            rd_bank_o = mem_q[rd_mode_i];
        end
    end

endmodule

// File: rtl/alt_vipitc140_is2vid_mode_calc.sv
// IS2VID mode calculator: snapshots a mode bank on request, derives the
// output timing over three calculation cycles and commits it at frame end.
// Optional mode-match scanner enabled by defining IS2VID_MODE_MATCH_EN.
module alt_vipitc140_is2vid_mode_calc
    import alt_vipitc140_is2vid_pkg::*;
#(
    parameter  int CNT_W     = TIMING_W,
    parameter  int NUM_MODES = 4,
    parameter  int TRS       = 4,
    localparam int MODE_W    = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                wr_en,
    input  logic [MODE_W-1:0]   wr_mode,
    input  logic [4:0]          wr_addr,
    input  logic [CNT_W-1:0]    wr_data,
    input  logic                req_valid,
    input  logic [MODE_W-1:0]   req_mode,
    output logic                req_ready,
    input  logic                frame_end,
`ifdef IS2VID_MODE_MATCH_EN
    input  logic                match_req,
    input  logic [CNT_W-1:0]    match_width,
    input  logic [CNT_W-1:0]    match_height,
    input  logic                match_interlaced,
    output logic                match_done,
    output logic                match_found,
    output logic [MODE_W-1:0]   match_idx,
`endif
    output mode_timing_t        timing,
    output logic [MODE_W-1:0]   cur_mode,
    output logic                done,
    output logic                err
);

    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TRS_C = CNT_W'(TRS);

    mode_state_e                     state_q, state_d;
    logic [MODE_W-1:0]               mode_q, rd_mode, cur_mode_q;
    logic [NUM_FIELDS-1:0][CNT_W-1:0] rd_bank, fld_q;
    mode_timing_t                    res_q, calc3_d, timing_q;
    logic                            done_q, err_q, req_ready_q;
    logic                            accept, reject, scan_d, il;
    logic [CNT_W-1:0]                f1_start, f2_start, tlc0_full, tlc1_full;

    alt_vipitc140_is2vid_mode_bank #(
        .CNT_W     (CNT_W),
        .NUM_MODES (NUM_MODES),
        .MODE_W    (MODE_W)
    ) u_bank (
        .clk_i     (clk),
        .rst_n_i   (reset_n),
        .wr_en_i   (wr_en),
        .wr_mode_i (wr_mode),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_mode_i (rd_mode),
        .rd_bank_o (rd_bank)
    );

    assign accept = (state_q == ST_IDLE) && req_ready_q && req_valid &&  rd_bank[FLD_CONTROL][CTRL_BANK_VALID];
    assign reject = (state_q == ST_IDLE) && req_ready_q && req_valid && !rd_bank[FLD_CONTROL][CTRL_BANK_VALID];
    assign il     = fld_q[FLD_CONTROL][CTRL_INTERLACED];

`ifdef IS2VID_MODE_MATCH_EN
    logic              scan_q, scan_start, scan_hit, scan_last;
    logic [MODE_W-1:0] scan_idx_q, match_idx_q;
    logic              match_done_q, match_found_q;
    logic [CNT_W-1:0]  scan_v_active;

    assign rd_mode       = scan_q ? scan_idx_q : ((state_q == ST_IDLE) ? req_mode : mode_q);
    assign scan_start    = (state_q == ST_IDLE) && req_ready_q && match_req && !req_valid;
    assign scan_v_active = rd_bank[FLD_LINE_COUNT_F0] +
                           (rd_bank[FLD_CONTROL][CTRL_INTERLACED] ? rd_bank[FLD_LINE_COUNT_F1] : '0);
    assign scan_hit      = scan_q && rd_bank[FLD_CONTROL][CTRL_BANK_VALID] &&
                           (rd_bank[FLD_SAMPLE_COUNT_F0] == match_width) &&
                           (scan_v_active == match_height) &&
                           (rd_bank[FLD_CONTROL][CTRL_INTERLACED] == match_interlaced);
    assign scan_last     = (int'(scan_idx_q) == NUM_MODES - 1);
    assign scan_d        = scan_start || (scan_q && !scan_hit && !scan_last);

    // Linear scan of banks from index 0; first matching valid bank wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_q        <= 1'b0;
            scan_idx_q    <= '0;
            match_done_q  <= 1'b0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
        end else begin
            scan_q       <= scan_d;
            match_done_q <= scan_q && (scan_hit || scan_last);
            if (scan_start) begin
                scan_idx_q <= '0;
            end else if (scan_q) begin
                scan_idx_q <= scan_idx_q + MODE_W'(1);
            end
            if (scan_q && (scan_hit || scan_last)) begin
                match_found_q <= scan_hit;
                match_idx_q   <= scan_idx_q;
            end
        end
    end

    assign match_done  = match_done_q;
    assign match_found = match_found_q;
    assign match_idx   = match_idx_q;
`else
    assign rd_mode = (state_q == ST_IDLE) ? req_mode : mode_q;
    assign scan_d  = 1'b0;
`endif

    // Controller next state: fixed three-cycle calculation then wait for frame end
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (accept) state_d = ST_LOAD;
            ST_LOAD:     state_d = ST_CALC1;
            ST_CALC1:    state_d = ST_CALC2;
            ST_CALC2:    state_d = ST_CALC3;
            ST_CALC3:    state_d = ST_WAIT_EOF;
            ST_WAIT_EOF: if (frame_end) state_d = ST_COMMIT;
            ST_COMMIT:   state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Controller state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Final-stage results, built from the snapshot and earlier-stage values
    always_comb begin
        calc3_d   = res_q;
        f1_start  = res_q.v1_rise + fld_q[FLD_V1_FRONT_PORCH];
        f2_start  = res_q.v2_rise + fld_q[FLD_V_FRONT_PORCH];
        tlc0_full = fld_q[FLD_LINE_COUNT_F0] + (fld_q[FLD_V_BLANK] - fld_q[FLD_V_FRONT_PORCH]
                    + fld_q[FLD_V1_FRONT_PORCH]) - ONE;
        tlc1_full = fld_q[FLD_LINE_COUNT_F1] + (fld_q[FLD_V1_BLANK] - fld_q[FLD_V1_FRONT_PORCH]
                    + fld_q[FLD_V_FRONT_PORCH]) - ONE;
        calc3_d.v_total_m1          = res_q.v_total - ONE;
        calc3_d.ap_line_end         = res_q.v_total - fld_q[FLD_AP_LINE];
        calc3_d.sav                 = fld_q[FLD_H_BLANK] - TRS_C;
        calc3_d.h_sync_end          = fld_q[FLD_H_FRONT_PORCH] + fld_q[FLD_H_SYNC_LENGTH];
        calc3_d.f1_v_end            = res_q.v1_rise + fld_q[FLD_V1_BLANK];
        calc3_d.f1_v_start          = f1_start;
        calc3_d.f1_v_sync_end       = f1_start + fld_q[FLD_V1_SYNC_LENGTH];
        calc3_d.f2_v_start          = f2_start;
        calc3_d.f2_v_sync_end       = f2_start + fld_q[FLD_V_SYNC_LENGTH];
        calc3_d.f_rising            = fld_q[FLD_F_RISING_EDGE] - fld_q[FLD_AP_LINE];
        calc3_d.f_falling           = res_q.v_total - (fld_q[FLD_AP_LINE] - fld_q[FLD_F_FALLING_EDGE]);
        calc3_d.f2_anc              = res_q.v_total - (fld_q[FLD_AP_LINE] - fld_q[FLD_ANC_LINE]);
        calc3_d.f1_anc              = fld_q[FLD_V1_ANC_LINE] - fld_q[FLD_AP_LINE];
        calc3_d.total_line_count_f0 = tlc0_full[12:0];
        calc3_d.total_line_count_f1 = tlc1_full[12:0];
        calc3_d.interlaced          = il;
        calc3_d.serial              = fld_q[FLD_CONTROL][CTRL_SERIAL];
    end

    // Working datapath: bank snapshot and staged arithmetic
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q <= '0;
            fld_q  <= '0;
            res_q  <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE:  if (accept) mode_q <= req_mode;
                ST_LOAD:  fld_q <= rd_bank;
                ST_CALC1: begin
                    res_q.v_active   <= fld_q[FLD_LINE_COUNT_F0] + (il ? fld_q[FLD_LINE_COUNT_F1] : '0);
                    res_q.h_total_m1 <= fld_q[FLD_SAMPLE_COUNT_F0] + fld_q[FLD_H_BLANK] - ONE;
                end
                ST_CALC2: begin
                    res_q.v_total <= res_q.v_active + (il ? fld_q[FLD_V1_BLANK] : '0) + fld_q[FLD_V_BLANK];
                    res_q.v1_rise <= fld_q[FLD_V1_RISING_EDGE] - fld_q[FLD_AP_LINE];
                    res_q.v2_rise <= res_q.v_active + (il ? fld_q[FLD_V1_BLANK] : '0);
                end
                ST_CALC3: res_q <= calc3_d;
                default:  ;
            endcase
        end
    end

    // Committed outputs and status pulses; timing only moves in COMMIT
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timing_q    <= '0;
            cur_mode_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b0;
        end else begin
            done_q      <= (state_q == ST_COMMIT);
            err_q       <= reject;
            req_ready_q <= (state_d == ST_IDLE) && !scan_d;
            if (state_q == ST_COMMIT) begin
                timing_q   <= res_q;
                cur_mode_q <= mode_q;
            end
        end
    end

    assign timing    = timing_q;
    assign cur_mode  = cur_mode_q;
    assign done      = done_q;
    assign err       = err_q;
    assign req_ready = req_ready_q;

endmodule

// File: tb/tb_alt_vipitc140_is2vid_mode_calc.sv
// Directed bench for the IS2VID mode calculator with hand-computed
// expectations for 1080p/1080i banks, rejects, overwrites and resets.
module tb_alt_vipitc140_is2vid_mode_calc;
   import alt_vipitc140_is2vid_pkg::*;

   localparam int A_SC0   = 0;
   localparam int A_LC0   = 1;
   localparam int A_LC1   = 2;
   localparam int A_HB    = 3;
   localparam int A_HFP   = 4;
   localparam int A_HSYNC = 5;
   localparam int A_VB    = 6;
   localparam int A_V1B   = 7;
   localparam int A_VFP   = 8;
   localparam int A_VSYNC = 9;
   localparam int A_V1FP  = 10;
   localparam int A_V1SYN = 11;
   localparam int A_V1RE  = 12;
   localparam int A_AP    = 13;
   localparam int A_FRE   = 14;
   localparam int A_ANC   = 16;
   localparam int A_V1ANC = 17;
   localparam int A_CTRL  = 19;

   logic clk, reset_n;
   logic wrEn, reqValid, reqReady, frameEnd, done, err;
   logic [1:0] wrMode, reqMode, curMode;
   logic [4:0] wrAddr;
   logic [15:0] wrData;
   mode_timing_t timing;
`ifdef IS2VID_MODE_MATCH_EN
   logic matchReq, matchInterlaced, matchDone, matchFound;
   logic [15:0] matchWidth, matchHeight;
   logic [1:0] matchIdx;
`endif

   int assertCount = 0;
   int failCount = 0;
   int pulses;

   alt_vipitc140_is2vid_mode_calc dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .wr_en            (wrEn),
      .wr_mode          (wrMode),
      .wr_addr          (wrAddr),
      .wr_data          (wrData),
      .req_valid        (reqValid),
      .req_mode         (reqMode),
      .req_ready        (reqReady),
      .frame_end        (frameEnd),
`ifdef IS2VID_MODE_MATCH_EN
      .match_req        (matchReq),
      .match_width      (matchWidth),
      .match_height     (matchHeight),
      .match_interlaced (matchInterlaced),
      .match_done       (matchDone),
      .match_found      (matchFound),
      .match_idx        (matchIdx),
`endif
      .timing           (timing),
      .cur_mode         (curMode),
      .done             (done),
      .err              (err)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic writeField(input int mode, input int addr, input int data);
      wrEn = 1'b1;
      wrMode = 2'(mode);
      wrAddr = 5'(addr);
      wrData = 16'(data);
      tick();
      wrEn = 1'b0;
   endtask

   task automatic applyStimulus(input int mode);
      reqValid = 1'b1;
      reqMode = 2'(mode);
      tick();
      reqValid = 1'b0;
   endtask

   task automatic pulseFrameEnd();
      frameEnd = 1'b1;
      tick();
      frameEnd = 1'b0;
   endtask

   task automatic waitDone(input int cycles, output int count);
      count = 0;
      repeat (cycles) begin
         tick();
         if (done) count++;
      end
   endtask

   task automatic loadProgressive(input int mode);
      writeField(mode, A_SC0, 1920);
      writeField(mode, A_LC0, 1080);
      writeField(mode, A_HB, 280);
      writeField(mode, A_HFP, 88);
      writeField(mode, A_HSYNC, 44);
      writeField(mode, A_VB, 45);
      writeField(mode, A_VFP, 4);
      writeField(mode, A_VSYNC, 5);
      writeField(mode, A_CTRL, 4);
   endtask

   task automatic loadInterlaced(input int mode);
      writeField(mode, A_SC0, 1920);
      writeField(mode, A_LC0, 540);
      writeField(mode, A_LC1, 540);
      writeField(mode, A_HB, 280);
      writeField(mode, A_VB, 22);
      writeField(mode, A_V1B, 23);
      writeField(mode, A_V1FP, 2);
      writeField(mode, A_V1SYN, 5);
      writeField(mode, A_V1RE, 563);
      writeField(mode, A_AP, 20);
      writeField(mode, A_FRE, 563);
      writeField(mode, A_ANC, 10);
      writeField(mode, A_V1ANC, 583);
      writeField(mode, A_CTRL, 5);
   endtask

   initial begin
      reset_n = 1'b0;
      wrEn = 1'b0; wrMode = '0; wrAddr = '0; wrData = '0;
      reqValid = 1'b0; reqMode = '0; frameEnd = 1'b0;
`ifdef IS2VID_MODE_MATCH_EN
      matchReq = 1'b0; matchWidth = '0; matchHeight = '0; matchInterlaced = 1'b0;
`endif
      repeat (2) @(negedge clk);
      checkOutput("reset_ready", 32'(reqReady), 0);
      checkOutput("reset_done", 32'(done), 0);
      checkOutput("reset_err", 32'(err), 0);
      checkOutput("reset_timing_zero", 32'(timing == '0), 1);
      checkOutput("reset_cur_mode", 32'(curMode), 0);
      reset_n = 1'b1;
      tick();
      checkOutput("ready_after_release", 32'(reqReady), 1);

      // 1080p in bank 0
      loadProgressive(0);
      applyStimulus(0);
      checkOutput("ready_busy", 32'(reqReady), 0);
      waitDone(8, pulses);
      checkOutput("p_no_done_before_eof", 32'(pulses), 0);
      checkOutput("p_timing_held", 32'(timing.h_total_m1), 0);
      pulseFrameEnd();
      waitDone(10, pulses);
      checkOutput("p_done_count", 32'(pulses), 1);
      checkOutput("p_h_total_m1", 32'(timing.h_total_m1), 2199);
      checkOutput("p_v_total_m1", 32'(timing.v_total_m1), 1124);
      checkOutput("p_sav", 32'(timing.sav), 276);
      checkOutput("p_h_sync_end", 32'(timing.h_sync_end), 132);
      checkOutput("p_f2_v_start", 32'(timing.f2_v_start), 1084);
      checkOutput("p_f2_v_sync_end", 32'(timing.f2_v_sync_end), 1089);
      checkOutput("p_tlc0", 32'(timing.total_line_count_f0), 1120);
      checkOutput("p_interlaced", 32'(timing.interlaced), 0);
      checkOutput("p_cur_mode", 32'(curMode), 0);

      // 1080i in bank 1
      loadInterlaced(1);
      applyStimulus(1);
      repeat (5) tick();
      pulseFrameEnd();
      waitDone(10, pulses);
      checkOutput("i_done_count", 32'(pulses), 1);
      checkOutput("i_v_total_m1", 32'(timing.v_total_m1), 1124);
      checkOutput("i_f2_v_start", 32'(timing.f2_v_start), 1103);
      checkOutput("i_v1_rise", 32'(timing.v1_rise), 543);
      checkOutput("i_f1_v_end", 32'(timing.f1_v_end), 566);
      checkOutput("i_f1_v_sync_end", 32'(timing.f1_v_sync_end), 550);
      checkOutput("i_f2_anc", 32'(timing.f2_anc), 1115);
      checkOutput("i_f1_anc", 32'(timing.f1_anc), 563);
      checkOutput("i_tlc0", 32'(timing.total_line_count_f0), 563);
      checkOutput("i_tlc1", 32'(timing.total_line_count_f1), 560);
      checkOutput("i_interlaced", 32'(timing.interlaced), 1);
      checkOutput("i_cur_mode", 32'(curMode), 1);

      // Request of an empty bank is rejected
      applyStimulus(3);
      checkOutput("rej_err", 32'(err), 1);
      checkOutput("rej_ready", 32'(reqReady), 1);
      tick();
      checkOutput("rej_err_pulse", 32'(err), 0);
      checkOutput("rej_cur_mode", 32'(curMode), 1);
      checkOutput("rej_timing", 32'(timing.v_total_m1), 1124);

      // Overwrite during calculation does not affect result in flight
      applyStimulus(0);
      tick();
      tick();
      writeField(0, A_HB, 100);
      waitDone(6, pulses);
      checkOutput("ow_no_done_before_eof", 32'(pulses), 0);
      checkOutput("ow_cur_mode_held", 32'(curMode), 1);
      pulseFrameEnd();
      waitDone(10, pulses);
      checkOutput("ow_done_count", 32'(pulses), 1);
      checkOutput("ow_h_total_m1", 32'(timing.h_total_m1), 2199);
      checkOutput("ow_sav", 32'(timing.sav), 276);
      checkOutput("ow_cur_mode", 32'(curMode), 0);

      // Same-cycle write and request: new value used
      wrEn = 1'b1; wrMode = 2'd0; wrAddr = 5'(A_HB); wrData = 16'd300;
      reqValid = 1'b1; reqMode = 2'd0;
      tick();
      wrEn = 1'b0; reqValid = 1'b0;
      repeat (5) tick();
      pulseFrameEnd();
      waitDone(10, pulses);
      checkOutput("wr_req_done", 32'(pulses), 1);
      checkOutput("wr_req_h_total_m1", 32'(timing.h_total_m1), 2219);
      checkOutput("wr_req_sav", 32'(timing.sav), 296);

      // Reset while waiting for frame end
      applyStimulus(1);
      repeat (5) tick();
      reset_n = 1'b0;
      #1;
      checkOutput("rst_timing_zero", 32'(timing == '0), 1);
      checkOutput("rst_cur_mode", 32'(curMode), 0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      pulseFrameEnd();
      waitDone(10, pulses);
      checkOutput("rst_no_done", 32'(pulses), 0);
      checkOutput("rst_timing_still_zero", 32'(timing == '0), 1);
      applyStimulus(0);
      checkOutput("rst_bank_cleared_err", 32'(err), 1);

`ifdef IS2VID_MODE_MATCH_EN
      // Match scan: banks 0 and 2 progressive 1080p, bank 1 interlaced
      loadProgressive(0);
      loadInterlaced(1);
      loadProgressive(2);
      tick();
      matchReq = 1'b1; matchWidth = 16'd1920; matchHeight = 16'd1080; matchInterlaced = 1'b0;
      tick();
      matchReq = 1'b0;
      pulses = 0;
      for (int i = 0; i < 8 && pulses == 0; i++) begin
         if (matchDone) pulses = 1;
         else tick();
      end
      checkOutput("m_done_seen", 32'(pulses), 1);
      checkOutput("m_found", 32'(matchFound), 1);
      checkOutput("m_idx", 32'(matchIdx), 0);
      tick();
      matchReq = 1'b1; matchInterlaced = 1'b1;
      tick();
      matchReq = 1'b0;
      pulses = 0;
      for (int i = 0; i < 8 && pulses == 0; i++) begin
         if (matchDone) pulses = 1;
         else tick();
      end
      checkOutput("mi_done_seen", 32'(pulses), 1);
      checkOutput("mi_found", 32'(matchFound), 1);
      checkOutput("mi_idx", 32'(matchIdx), 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/alt_vipitc140_is2vid_mode_calc.md
ALT_VIPITC140_IS2VID_MODE_CALC -- requirements
Module: alt_vipitc140_is2vid_mode_calc

Interface
REQ-001 Parameter CNT_W, default 16: width of every timing field and arithmetic result.
REQ-002 Parameter NUM_MODES, default 4: number of mode banks; MODE_W = clog2(NUM_MODES), minimum 1.
REQ-003 Parameter TRS, default 4: TRS word length subtracted from h_blank to form sav.
REQ-004 clk  in  1  single clock, all logic rising-edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 wr_en / wr_mode / wr_addr / wr_data  in  1 / MODE_W / 5 / CNT_W  bank write port, field map per package.
REQ-007 req_valid / req_mode  in  1 / MODE_W  mode-change request; req_ready  out  1.
REQ-008 frame_end  in  1  one-cycle pulse from output timing counters at last sample of frame.
REQ-009 timing  out  mode_timing_t  committed derived timing (totals, sav, sync, blanking, F edges, anc starts, 13-bit total line counts, interlaced, serial).
REQ-010 cur_mode  out  MODE_W; done  out  1  commit pulse; err  out  1  rejected-request pulse.

Function
REQ-011 Bank storage: NUM_MODES x 20 fields of CNT_W; field 19 = control (bit0 interlaced, bit1 serial, bit2 bank_valid); addresses 20-31 ignored.
REQ-012 FSM states IDLE, LOAD, CALC1, CALC2, CALC3, WAIT_EOF, COMMIT; req_ready high only in IDLE.
REQ-013 IDLE: req_valid & bank_valid -> LOAD; req_valid & !bank_valid -> err pulse one cycle, stay IDLE.
REQ-014 LOAD: snapshot selected bank into working registers; later writes to that bank do not affect the calculation in flight.
REQ-015 CALC1: v_active = line_count_f0 + (interlaced ? line_count_f1 : 0); h_total_m1 = sample_count_f0 + h_blank - 1.
REQ-016 CALC2: v_total = v_active + (interlaced ? v1_blank : 0) + v_blank; v1_rise = v1_rising_edge - ap_line; v2_rise = v_active + (interlaced ? v1_blank : 0).
REQ-017 CALC3: remaining fields: v_total_m1, ap_line_end = v_total - ap_line, sav = h_blank - TRS, h_sync_end = h_front_porch + h_sync_length, f1_v_end = v1_rise + v1_blank, f1/f2 v_sync start = rise + respective front porch, end = start + respective sync length, f_rising = f_rising_edge - ap_line, f_falling = v_total - (ap_line - f_falling_edge), f2_anc = v_total - (ap_line - anc_line), f1_anc = v1_anc_line - ap_line, total_line_count_f0/f1 = line_count + (blank - own fp + other fp) - 1.
REQ-018 All arithmetic modulo 2^CNT_W; total line counts truncated to low 13 bits; no saturation.
REQ-019 CALC3 -> WAIT_EOF; WAIT_EOF -> COMMIT on frame_end; frame_end in the same cycle as CALC3 completion is not used.
REQ-020 COMMIT: timing and cur_mode update together, done pulses one cycle, -> IDLE; timing never changes outside COMMIT.
REQ-021 Minimum latency req accept to done: 5 cycles plus wait for next frame_end.
REQ-022 Write to bank and request of same bank in the same cycle: LOAD sees the new value.

Reset
REQ-023 reset_n low: FSM IDLE, timing all zero, cur_mode 0, done/err/req_ready low until first clk edge after release, all bank fields zero (bank_valid clear).
REQ-024 Reset mid-calculation aborts with no commit; assertion is immediate, release synchronous to clk.

Configuration
REQ-025 Macro IS2VID_MODE_MATCH_EN present: inputs match_req, match_width, match_height, match_interlaced; outputs match_done, match_found, match_idx; scans valid banks one per cycle from bank 0, first equal sample_count_f0, v_active, interlaced wins; match_done pulses after at most NUM_MODES+1 cycles; scan only from IDLE, blocks req_ready while scanning.
REQ-026 Macro absent: match ports and scan logic not present; all other behaviour identical.

Structure
REQ-027 Package alt_vipitc140_is2vid_pkg holds mode_timing_t, field address constants, control bit positions, FSM state enum.
REQ-028 One sub-module alt_vipitc140_is2vid_mode_bank holds bank storage with write port and one combinational read port.

Verification
REQ-029 1080p bank 0 (1920, 1080, h_blank 280, h_fp 88, h_sync 44, v_blank 45), request, frame_end -> h_total_m1 2199, v_total_m1 1124, sav 276, h_sync_end 132, done once.
REQ-030 1080i bank 1 (540/540 lines, v_blank 22, v1_blank 23, interlaced) -> v_total_m1 1124, f2_v_start 1103.
REQ-031 Request bank with bank_valid 0 -> err one cycle, timing unchanged, req_ready stays high.
REQ-032 Overwrite bank 0 h_blank during CALC2 -> committed result uses old value; no commit before frame_end.
REQ-033 Assert reset_n during WAIT_EOF -> timing zero, no done after release.
REQ-034 With IS2VID_MODE_MATCH_EN, match 1920x1080 progressive, banks 0 and 2 match -> match_found 1, match_idx 0.
